// File: rtl/boot_loader_ctrl.sv
// Power-up program loader: sends a sync byte, receives a length-prefixed program over UART
// and writes it into instruction memory. Optional trailing XOR checksum: BOOT_LOADER_CHECKSUM_EN.
module boot_loader_ctrl #(
    parameter int unsigned IMEM_ADDR_W = 14,
    parameter logic [7:0]  SYNC_BYTE   = 8'hAA
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   go,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   tx_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_req,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_din,
    output logic [2:0]             mode,
    output logic                   cpu_rstn,
    output logic [IMEM_ADDR_W:0]   words_loaded,
    output logic                   err
);
    localparam logic [2:0]  MODE_LOAD  = 3'd1;
    localparam logic [2:0]  MODE_EXEC  = 3'd2;
    localparam logic [2:0]  MODE_ERROR = 3'd3;
    localparam logic [32:0] LEN_CAP    = 33'd1 << IMEM_ADDR_W;

`ifdef BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN, S_WORDS, S_CHECK, S_DRAIN, S_DONE, S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN, S_WORDS, S_DRAIN, S_DONE, S_ERROR
    } state_t;
`endif

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] len;
    logic        len_full;
    logic [23:0] asm_word;
    logic        len_too_big;
    logic        last_word;

    assign len_too_big = {1'b0, len} > LEN_CAP;
    // The write being issued this cycle is word index len-1.
    assign last_word   = imem_we && (32'(words_loaded) == len - 32'd1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] chk_byte;
    logic       chk_got;
    logic       byte_accept;

    // Every length or data byte the FSM keeps is folded into the running XOR.
    assign byte_accept = rx_valid && (
        (state == S_LEN && (!len_full || (len != 32'd0 && !len_too_big))) ||
        (state == S_WORDS && !last_word));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csum <= '0;
        end else if (byte_accept) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    // NOTE: all state and outputs use non-blocking assignments so every output is a clean flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            tx_data      <= '0;
            tx_req       <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_din     <= '0;
            mode         <= '0;
            cpu_rstn     <= 1'b0;
            words_loaded <= '0;
            err          <= 1'b0;
            byte_cnt     <= '0;
            len          <= '0;
            len_full     <= 1'b0;
            asm_word     <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            chk_byte     <= '0;
            chk_got      <= 1'b0;
`endif
        end else begin
            tx_req  <= 1'b0;
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state <= S_SYNC;
                        mode  <= MODE_LOAD;
                    end
                end
                S_SYNC: begin
                    if (!tx_busy) begin
                        tx_data <= SYNC_BYTE;
                        tx_req  <= 1'b1;
                        state   <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (len_full) begin
                        len_full <= 1'b0;
                        if (len == 32'd0) begin
                            state <= S_DRAIN;
                        end else if (len_too_big) begin
                            state <= S_ERROR;
                            mode  <= MODE_ERROR;
                            err   <= 1'b1;
                        end else begin
                            state <= S_WORDS;
                            if (rx_valid) begin
                                asm_word <= {asm_word[15:0], rx_data};
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                    end else if (rx_valid) begin
                        len      <= {len[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            len_full <= 1'b1;
                        end
                    end
                end
                S_WORDS: begin
                    if (imem_we) begin
                        words_loaded <= words_loaded + 1'b1;
                    end
                    if (last_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        state <= S_CHECK;
                        if (rx_valid) begin
                            chk_byte <= rx_data;
                            chk_got  <= 1'b1;
                        end
`else
                        state <= S_DRAIN;
`endif
                    end else if (rx_valid) begin
                        asm_word <= {asm_word[15:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we   <= 1'b1;
                            imem_din  <= {asm_word, rx_data};
                            imem_addr <= words_loaded[IMEM_ADDR_W-1:0];
                        end
                    end
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (chk_got) begin
                        chk_got <= 1'b0;
                        if (chk_byte == csum) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_ERROR;
                            mode  <= MODE_ERROR;
                            err   <= 1'b1;
                        end
                    end else if (rx_valid) begin
                        chk_byte <= rx_data;
                        chk_got  <= 1'b1;
                    end
                end
`endif
                // One idle cycle lets the last write land before the core leaves reset.
                S_DRAIN: begin
                    state    <= S_DONE;
                    mode     <= MODE_EXEC;
                    cpu_rstn <= 1'b1;
                end
                S_DONE:  state <= S_DONE;
                S_ERROR: state <= S_ERROR;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: random programs checked against a byte-stream model.
`timescale 1ns/1ps
module tb_boot_loader_ctrl;
    localparam int         AW   = 4;
    localparam int         WL_W = AW + 1;
    localparam logic [7:0] SYNC = 8'hAA;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              go = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              tx_busy = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_req;
    logic              imem_we;
    logic [AW-1:0]     imem_addr;
    logic [31:0]       imem_din;
    logic [2:0]        mode;
    logic              cpu_rstn;
    logic [AW:0]       words_loaded;
    logic              err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Observed writes and events, captured on the falling edge.
    int          mon_cyc[$];
    int          mon_addr[$];
    logic [31:0] mon_data[$];
    int          tx_pulses = 0;
    logic [7:0]  tx_seen = '0;
    int          done_cyc = -1;

    logic [7:0]  prog[$];
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  csum_flip = 8'h00;
`endif

    boot_loader_ctrl #(.IMEM_ADDR_W(AW), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .rstn(rstn), .go(go), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_req(tx_req), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_din(imem_din), .mode(mode), .cpu_rstn(cpu_rstn),
        .words_loaded(words_loaded), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            mon_cyc.delete();
            mon_addr.delete();
            mon_data.delete();
            tx_pulses <= 0;
            done_cyc  <= -1;
        end else begin
            if (imem_we) begin
                mon_cyc.push_back(cyc);
                mon_addr.push_back(int'(imem_addr));
                mon_data.push_back(imem_din);
            end
            if (tx_req) begin
                tx_pulses <= tx_pulses + 1;
                tx_seen   <= tx_data;
            end
            if (mode == 3'd2 && done_cyc < 0) done_cyc <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic apply_reset();
        go       = 1'b0;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic fill_random_prog();
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(8'($urandom));
    endtask

    // Full load sequence; expectations come from the host-side view of the byte stream.
    task automatic run_program(input string name, input logic [31:0] len,
                               input int max_gap, input int busy_cycles);
        int          exp_cyc[$];
        int          exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] word = '0;
        logic [2:0]  exp_mode;
        int          c;
        int          last_len_cyc = 0;
        bit          too_big;
        bit          has_words;
        bit          seen = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        logic [7:0]  csum = 8'h00;
`endif
        too_big   = ({1'b0, len} > (33'd1 << AW));
        has_words = !too_big && (len != 32'd0);
        exp_mode  = too_big ? 3'd3 : 3'd2;
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (has_words && csum_flip != 8'h00) exp_mode = 3'd3;
`endif
        apply_reset();
        tx_busy = (busy_cycles > 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (mode !== 3'd1 || cpu_rstn !== 1'b0) begin
            errors++;
            $display("FAIL %s load_mode: got mode=%0d cpu_rstn=%b, want mode=1 cpu_rstn=0", name, mode, cpu_rstn);
        end
        for (int i = 0; i < busy_cycles; i++) begin
            tick();
            checks++;
            if (tx_req !== 1'b0) begin
                errors++;
                $display("FAIL %s tx_req_while_busy: got %b, want 0", name, tx_req);
            end
        end
        tx_busy = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = (tx_req === 1'b1);
        end
        checks++;
        if (!seen || tx_data !== SYNC) begin
            errors++;
            $display("FAIL %s sync_pulse: seen=%b tx_data=%h, want pulse with %h", name, seen, tx_data, SYNC);
        end

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            last_len_cyc = cyc;
            send_byte(len[31-8*i -: 8]);
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum ^= len[31-8*i -: 8];
`endif
        end
        checks++;
        if (mode !== 3'd1) begin
            errors++;
            $display("FAIL %s mode_after_len: got %0d, want 1", name, mode);
        end

        if (has_words) begin
            for (int i = 0; i < 4 * int'(len); i++) begin
                repeat ($urandom_range(max_gap, 0)) tick();
                word = {word[23:0], prog[i]};
                c = cyc;
                send_byte(prog[i]);
`ifdef BOOT_LOADER_CHECKSUM_EN
                csum ^= prog[i];
`endif
                if (i % 4 == 3) begin
                    exp_cyc.push_back(c + 1);
                    exp_addr.push_back(i / 4);
                    exp_data.push_back(word);
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            repeat ($urandom_range(max_gap, 0)) tick();
            send_byte(csum ^ csum_flip);
`endif
        end

        for (int i = 0; i < 60 && mode !== 3'd2 && mode !== 3'd3; i++) tick();
        repeat (4) tick();

        checks++;
        if (mode !== exp_mode) begin
            errors++;
            $display("FAIL %s final_mode: got %0d, want %0d", name, mode, exp_mode);
        end
        checks++;
        if (err !== (exp_mode == 3'd3) || cpu_rstn !== (exp_mode == 3'd2)) begin
            errors++;
            $display("FAIL %s err_cpu_rstn: got err=%b cpu_rstn=%b, want err=%b cpu_rstn=%b",
                     name, err, cpu_rstn, exp_mode == 3'd3, exp_mode == 3'd2);
        end
        checks++;
        if (tx_pulses !== 1 || tx_seen !== SYNC) begin
            errors++;
            $display("FAIL %s tx_pulse_count: got %0d pulses data=%h, want 1 pulse data=%h", name, tx_pulses, tx_seen, SYNC);
        end
        checks++;
        if (mon_cyc.size() !== exp_cyc.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d, want %0d", name, mon_cyc.size(), exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < mon_cyc.size(); i++) begin
            checks++;
            if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL %s write_%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                         name, i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
            end
            checks++;
            if (mon_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL %s write_%0d_cycle: got %0d, want %0d", name, i, mon_cyc[i], exp_cyc[i]);
            end
        end
        checks++;
        if (words_loaded !== WL_W'(exp_cyc.size())) begin
            errors++;
            $display("FAIL %s words_loaded: got %0d, want %0d", name, words_loaded, exp_cyc.size());
        end
`ifndef BOOT_LOADER_CHECKSUM_EN
        if (exp_mode == 3'd2) begin
            c = (exp_cyc.size() > 0) ? exp_cyc[exp_cyc.size()-1] + 2 : last_len_cyc + 3;
            checks++;
            if (done_cyc !== c) begin
                errors++;
                $display("FAIL %s exec_cycle: got %0d, want %0d", name, done_cyc, c);
            end
        end
`endif
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #3 rstn = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_req, imem_we, imem_addr, imem_din, mode, cpu_rstn, words_loaded, err} !== '0) begin
            errors++;
            $display("FAIL reset_values: got mode=%0d tx_req=%b we=%b wl=%0d err=%b cpu_rstn=%b, want all 0",
                     mode, tx_req, imem_we, words_loaded, err, cpu_rstn);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        send_byte(8'h5A);
        repeat (3) tick();
        checks++;
        if ({tx_data, tx_req, imem_we, imem_addr, imem_din, mode, cpu_rstn, words_loaded, err} !== '0) begin
            errors++;
            $display("FAIL idle_hold: got mode=%0d tx_req=%b we=%b wl=%0d, want all 0", mode, tx_req, imem_we, words_loaded);
        end
    endtask

    task automatic test_two_words();
        prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        run_program("two_words", 32'd2, 2, 2);
    endtask

    task automatic test_len_zero();
        run_program("len_zero", 32'd0, 1, 0);
    endtask

    task automatic test_len_bounds();
        fill_random_prog();
        run_program("len_max", 32'd16, 0, 1);
        run_program("len_17", 32'd17, 1, 0);
        run_program("len_huge", 32'h8000_0001, 0, 0);
    endtask

    task automatic test_back_to_back();
        prog = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h12, 8'h34, 8'h56, 8'h78};
        run_program("back_to_back", 32'd2, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            fill_random_prog();
            run_program($sformatf("random_%0d", n), 32'($urandom_range(16, 1)),
                        $urandom_range(2, 0), $urandom_range(2, 0));
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) send_byte((i == 3) ? 8'h03 : 8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        checks++;
        if (words_loaded !== WL_W'(1) || mode !== 3'd1) begin
            errors++;
            $display("FAIL mid_load_progress: got wl=%0d mode=%0d, want wl=1 mode=1", words_loaded, mode);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_req, imem_we, imem_addr, imem_din, mode, cpu_rstn, words_loaded, err} !== '0) begin
            errors++;
            $display("FAIL async_abort: got mode=%0d we=%b addr=%0d din=%h wl=%0d, want all 0",
                     mode, imem_we, imem_addr, imem_din, words_loaded);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        send_byte(8'h99);
        repeat (2) tick();
        checks++;
        if (mode !== 3'd0 || imem_we !== 1'b0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL no_resume: got mode=%0d we=%b wl=%0d, want 0 0 0", mode, imem_we, words_loaded);
        end
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        prog = '{8'h11, 8'h22, 8'h33, 8'h44};
        csum_flip = 8'h00;
        run_program("csum_good", 32'd1, 0, 0);
        csum_flip = 8'h45;
        run_program("csum_bad", 32'd1, 1, 0);
        csum_flip = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_len_zero();
        test_len_bounds();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef BOOT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
